mini16sc_dbus_responder: RTL and testbench
==========================================

// Module: mini16sc_dbus_responder
// PURPOSE
// - Responder side of the mini16sc data-memory bus. Sits between the CPU data port and the system.
// - Serves CPU loads and stores from an internal word RAM.
// - Maps a small I/O window above the RAM: UART transmitter with TX FIFO, GPIO output, soft-reset request.
// - Optional free-running cycle counter in the same window.
// PARAMETERS
// - WIDTH_D    16  data word width; at least 16.
// - DEPTH_D     8  bus address width.
// - DEPTH_RAM   7  RAM address width. RAM occupies 0 .. 2**DEPTH_RAM-1. Must be < DEPTH_D.
// - IO_BASE  8'h80 I/O window base address. Must be >= 2**DEPTH_RAM.
// - FIFO_DEPTH  3  log2 of TX FIFO entries (8).
// - CLK_DIV   868  clk cycles per UART bit. Must be >= 2.
// PORTS
// - clk           in   1        clock
// - reset         in   1        synchronous, active-high
// - mem_d_r_addr  in   DEPTH_D  load address from CPU
// - mem_d_r_data  out  WIDTH_D  load data to CPU, registered
// - mem_d_w_addr  in   DEPTH_D  store address
// - mem_d_w_data  in   WIDTH_D  store data
// - mem_d_we      in   1        store strobe, one cycle per store
// - uart_txd      out  1        serial out, 8N1, idle high
// - gpio_out      out  WIDTH_D  GPIO register
// - soft_reset    out  1        one-cycle pulse, drives CPU soft_reset
// BEHAVIOUR
// - Reset values: mem_d_r_data=0, uart_txd=1, gpio_out=0, soft_reset=0.
//   Also cleared on reset: FIFO, overflow flag, UART FSM (IDLE), cycle counter.
//   RAM contents are not reset.
// - Read path:
//   - Always active, latency 1: mem_d_r_data(t+1) = value at mem_d_r_addr(t).
//   - Address is a RAM address (< 2**DEPTH_RAM): return RAM word.
//   - Address is an I/O register: return that register value.
//   - Any other address: return 0.
//   - Read and write to the same address in the same cycle: read returns the OLD value.
// - Write path: when mem_d_we=1 at a clock edge, the write decodes mem_d_w_addr.
//   Writes to unmapped addresses are ignored.
// - I/O map, as offsets from IO_BASE:
//   - +0 TXDATA (W): push w_data[7:0] to the FIFO.
//     - FIFO full: data dropped and sticky ovf=1.
//     - Reads of TXDATA return 0.
//   - +1 STATUS (R): {.., ovf[3], busy[2], empty[1], full[0]}, zero-extended.
//     - Any write to STATUS clears ovf.
//     - If a drop and a clear fall on the same cycle, ovf ends 1.
//   - +2 GPIO (R/W): full-width register, drives gpio_out.
//   - +3 CTRL (W): write with w_data[0]=1 pulses soft_reset high for exactly the next cycle.
//     - Reads of CTRL return 0.
//   - +4 CYCLE (R): present only with the macro (see CONFIGURATION).
// - TX FIFO:
//   - 2**FIFO_DEPTH x 8 bits, wrap-around read and write pointers, count of FIFO_DEPTH+1 bits.
//   - Push and pop in the same cycle:
//     - FIFO not empty: count unchanged.
//     - FIFO empty: the push is stored and the pop does not occur.
//   - A push when full is rejected even if a pop happens that same cycle.
// - UART FSM: IDLE -> START -> DATA -> STOP.
//   - IDLE: if FIFO not empty, pop into shift reg, go to START; else txd=1.
//   - START: txd=0 for CLK_DIV cycles.
//   - DATA: 8 bits LSB first, CLK_DIV cycles each, using a 3-bit bit counter.
//   - STOP: txd=1 for CLK_DIV cycles. Then, if FIFO not empty, pop and go straight to START
//     (no idle gap); else go to IDLE.
//   - Frame length = 10*CLK_DIV cycles.
//   - busy = (state != IDLE).
//   - uart_txd is driven from a register, so it has no glitches.
// - soft_reset does not reset this block. FIFO and UART keep draining through a CPU soft reset.
// - Reset mid-frame: uart_txd returns to 1 on the next edge and the FIFO is emptied.
// CONFIGURATION
// - MINI16SC_DBUS_RESP_CYCLE_EN defined:
//   - WIDTH_D-bit counter, +1 every clock, wraps at all-ones to 0.
//   - Readable at IO_BASE+4 with the same 1-cycle latency. Any write to +4 clears it to 0.
// - Not defined: no counter logic; IO_BASE+4 reads 0 and writes are ignored.
// TESTING (bench uses CLK_DIV=4)
// - RAM: store 16'hBEEF to 5, load 5 -> mem_d_r_data=16'hBEEF one cycle after the address.
//   Load from unmapped 8'hF0 -> 0.
// - Same-cycle hazard: RAM[9]=1; store 2 to 9 while reading 9 -> read returns 1; next read -> 2.
// - UART: write 8'hA5 to TXDATA -> uart_txd=0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each),
//   then 1. busy=1 for 40 cycles.
// - FIFO: 10 back-to-back TXDATA writes while the first frame sends.
//   -> full=1 after the 9th push, 10th dropped, ovf=1.
//   -> STATUS write clears ovf; 9 frames sent with no idle gaps.
// - Control: write 16'h1234 to GPIO -> gpio_out=16'h1234, read back 16'h1234.
//   Write 1 to CTRL -> soft_reset high exactly 1 cycle.
// - Reset mid-frame -> uart_txd=1, STATUS reads 16'h0002.
//   With the macro: CYCLE is cleared to 0 by reset and counts up from there.

Source files
------------

// File: rtl/mini16sc_dbus_responder.sv
// Data-bus responder for mini16sc: word RAM plus an I/O window with a UART TX FIFO, GPIO and a soft-reset request.
// Optional cycle counter at IO_BASE+4, enabled by MINI16SC_DBUS_RESP_CYCLE_EN.
module mini16sc_dbus_responder #(
    parameter int                 WIDTH_D    = 16,
    parameter int                 DEPTH_D    = 8,
    parameter int                 DEPTH_RAM  = 7,
    parameter logic [DEPTH_D-1:0] IO_BASE    = 8'h80,
    parameter int                 FIFO_DEPTH = 3,
    parameter int                 CLK_DIV    = 868
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DEPTH_D-1:0] mem_d_r_addr,
    output logic [WIDTH_D-1:0] mem_d_r_data,
    input  logic [DEPTH_D-1:0] mem_d_w_addr,
    input  logic [WIDTH_D-1:0] mem_d_w_data,
    input  logic               mem_d_we,
    output logic               uart_txd,
    output logic [WIDTH_D-1:0] gpio_out,
    output logic               soft_reset
);

    localparam logic [DEPTH_D-1:0] A_TXDATA = IO_BASE;
    localparam logic [DEPTH_D-1:0] A_STATUS = DEPTH_D'(IO_BASE + 1);
    localparam logic [DEPTH_D-1:0] A_GPIO   = DEPTH_D'(IO_BASE + 2);
    localparam logic [DEPTH_D-1:0] A_CTRL   = DEPTH_D'(IO_BASE + 3);
`ifdef MINI16SC_DBUS_RESP_CYCLE_EN
    localparam logic [DEPTH_D-1:0] A_CYCLE  = DEPTH_D'(IO_BASE + 4);
`endif

    localparam int                  RAM_WORDS = 2 ** DEPTH_RAM;
    localparam int                  FIFO_N    = 2 ** FIFO_DEPTH;
    localparam logic [FIFO_DEPTH:0] FIFO_FULL = (FIFO_DEPTH+1)'(FIFO_N);
    localparam int                  DIV_W     = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [WIDTH_D-1:0]    ram [0:RAM_WORDS-1];
    logic [7:0]            fifo_mem [0:FIFO_N-1];
    logic [FIFO_DEPTH-1:0] wr_ptr, rd_ptr;
    logic [FIFO_DEPTH:0]   count;
    logic                  fifo_empty, fifo_full, push_req, push, pop, ovf;
    state_t                state;
    logic [DIV_W-1:0]      div_cnt;
    logic [2:0]            bit_cnt;
    logic [7:0]            shift;
    logic                  last_tick, busy;
    logic                  r_is_ram, w_is_ram;
    logic [WIDTH_D-1:0]    status_word;
`ifdef MINI16SC_DBUS_RESP_CYCLE_EN
    logic [WIDTH_D-1:0]    cycle_cnt;
`endif

    assign r_is_ram    = (mem_d_r_addr[DEPTH_D-1:DEPTH_RAM] == '0);
    assign w_is_ram    = (mem_d_w_addr[DEPTH_D-1:DEPTH_RAM] == '0);
    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == FIFO_FULL);
    assign push_req    = mem_d_we && (mem_d_w_addr == A_TXDATA);
    assign push        = push_req && !fifo_full;
    assign last_tick   = (div_cnt == DIV_LAST);
    // Pop requires a non-empty FIFO, so a push into an empty FIFO never pops in the same cycle.
    assign pop         = !fifo_empty && ((state == IDLE) || (state == STOP && last_tick));
    assign busy        = (state != IDLE);
    assign status_word = {{(WIDTH_D-4){1'b0}}, ovf, busy, fifo_empty, fifo_full};

    always_ff @(posedge clk) begin
        if (mem_d_we && w_is_ram)
            ram[mem_d_w_addr[DEPTH_RAM-1:0]] <= mem_d_w_data;
    end

    always_ff @(posedge clk) begin
        if (reset)
            mem_d_r_data <= '0;
        else if (r_is_ram)
            mem_d_r_data <= ram[mem_d_r_addr[DEPTH_RAM-1:0]];
        else begin
            case (mem_d_r_addr)
                A_STATUS: mem_d_r_data <= status_word;
                A_GPIO:   mem_d_r_data <= gpio_out;
`ifdef MINI16SC_DBUS_RESP_CYCLE_EN
                A_CYCLE:  mem_d_r_data <= cycle_cnt;
`endif
                default:  mem_d_r_data <= '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= mem_d_w_data[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A drop wins over a same-cycle clear.
            if (push_req && fifo_full)
                ovf <= 1'b1;
            else if (mem_d_we && mem_d_w_addr == A_STATUS)
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            uart_txd <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    if (pop) begin
                        shift    <= fifo_mem[rd_ptr];
                        uart_txd <= 1'b0;
                        state    <= START;
                    end else
                        uart_txd <= 1'b1;
                end
                START: begin
                    if (last_tick) begin
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        uart_txd <= shift[0];
                        state    <= DATA;
                    end else
                        div_cnt <= div_cnt + 1'b1;
                end
                DATA: begin
                    if (last_tick) begin
                        div_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            uart_txd <= 1'b1;
                            state    <= STOP;
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            shift    <= {1'b0, shift[7:1]};
                            uart_txd <= shift[1];
                        end
                    end else
                        div_cnt <= div_cnt + 1'b1;
                end
                STOP: begin
                    if (last_tick) begin
                        div_cnt <= '0;
                        // Chain straight into the next start bit when more data is queued.
                        if (pop) begin
                            shift    <= fifo_mem[rd_ptr];
                            uart_txd <= 1'b0;
                            state    <= START;
                        end else
                            state <= IDLE;
                    end else
                        div_cnt <= div_cnt + 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    uart_txd <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out   <= '0;
            soft_reset <= 1'b0;
        end else begin
            if (mem_d_we && mem_d_w_addr == A_GPIO)
                gpio_out <= mem_d_w_data;
            soft_reset <= mem_d_we && (mem_d_w_addr == A_CTRL) && mem_d_w_data[0];
        end
    end

`ifdef MINI16SC_DBUS_RESP_CYCLE_EN
    always_ff @(posedge clk) begin
        if (reset || (mem_d_we && mem_d_w_addr == A_CYCLE))
            cycle_cnt <= '0;
        else
            cycle_cnt <= cycle_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_mini16sc_dbus_responder.sv
// Directed bench for mini16sc_dbus_responder with CLK_DIV=4; loads go through an expected-value queue.
module tb_mini16sc_dbus_responder;

    localparam int CD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  r_addr = '0;
    logic [7:0]  w_addr = '0;
    logic [15:0] w_data = '0;
    logic        we = 1'b0;
    logic [15:0] r_data, gpio;
    logic        txd, srst;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [15:0] exp_q[$];

    mini16sc_dbus_responder #(.CLK_DIV(CD)) dut (
        .clk(clk), .reset(reset),
        .mem_d_r_addr(r_addr), .mem_d_r_data(r_data),
        .mem_d_w_addr(w_addr), .mem_d_w_data(w_data), .mem_d_we(we),
        .uart_txd(txd), .gpio_out(gpio), .soft_reset(srst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic rd(input logic [7:0] a, input logic [15:0] e, input string tag);
        logic [15:0] x;
        r_addr = a;
        exp_q.push_back(e);
        tick();
        x = exp_q.pop_front();
        chk(tag, r_data, x);
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        w_addr = a; w_data = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic wait_start();
        for (int i = 0; i < 20 && txd !== 1'b0; i++) tick();
        chk("txd_start", {15'b0, txd}, 16'h0000);
    endtask

    // Expected line level k cycles into an 8N1 frame carrying byte b.
    function automatic logic fbit(input logic [7:0] b, input int k);
        if (k < CD) return 1'b0;
        if (k >= 9 * CD) return 1'b1;
        return b[(k - CD) / CD];
    endfunction

    function automatic logic [7:0] dat(input int i);
        return 8'(i * 29 + 8'h17);
    endfunction

    function automatic logic exp_chain(input int c);
        int j, k;
        if (c < 1) return 1'b1;
        j = (c - 1) / (10 * CD);
        k = (c - 1) % (10 * CD);
        if (j >= 9) return 1'b1;
        return fbit(dat(j), k);
    endfunction

    initial begin
        logic [15:0] st;

        // Reset values
        repeat (3) tick();
        chk("rst_rdata", r_data, 16'h0000);
        chk("rst_txd", {15'b0, txd}, 16'h0001);
        chk("rst_gpio", gpio, 16'h0000);
        chk("rst_srst", {15'b0, srst}, 16'h0000);
        reset = 1'b0;

        // RAM and decode
        wr(8'h05, 16'hBEEF);
        rd(8'h05, 16'hBEEF, "ram5");
        wr(8'h7F, 16'h7777);
        rd(8'h7F, 16'h7777, "ram_top");
        rd(8'hF0, 16'h0000, "unmapped_f0");
        rd(8'h80, 16'h0000, "txdata_rd");
        rd(8'h81, 16'h0002, "status_idle");
        rd(8'h83, 16'h0000, "ctrl_rd");

        // Same-cycle read/write returns the old word
        wr(8'h09, 16'h0001);
        w_addr = 8'h09; w_data = 16'h0002; we = 1'b1;
        rd(8'h09, 16'h0001, "hazard_old");
        we = 1'b0;
        rd(8'h09, 16'h0002, "hazard_new");

        // GPIO and CTRL
        wr(8'h82, 16'h1234);
        chk("gpio_out", gpio, 16'h1234);
        rd(8'h82, 16'h1234, "gpio_rd");
        chk("srst_before", {15'b0, srst}, 16'h0000);
        wr(8'h83, 16'h0001);
        chk("srst_pulse", {15'b0, srst}, 16'h0001);
        tick();
        chk("srst_after", {15'b0, srst}, 16'h0000);
        wr(8'h83, 16'h0002);
        chk("srst_bit0_clear", {15'b0, srst}, 16'h0000);

        // Single frame 0xA5, STATUS watched through the read port
        r_addr = 8'h81;
        tick();
        wr(8'h80, 16'h00A5);
        wait_start();
        for (int k = 0; k < 42; k++) begin
            chk($sformatf("a5_txd_%0d", k), {15'b0, txd}, {15'b0, (k < 10 * CD) ? fbit(8'hA5, k) : 1'b1});
            st = (k == 0) ? 16'h0000 : (k <= 10 * CD) ? 16'h0006 : 16'h0002;
            chk($sformatf("a5_status_%0d", k), r_data, st);
            tick();
        end

        // Ten back-to-back pushes: one popped at once, eight queued, the tenth dropped
        cyc = -1;
        for (int i = 0; i < 10; i++) begin
            w_addr = 8'h80; w_data = {8'h00, dat(i)}; we = 1'b1;
            tick();
        end
        we = 1'b0;
        r_addr = 8'h81;
        tick();
        chk("fifo_full_ovf", r_data, 16'h000D);
        w_addr = 8'h81; w_data = 16'h0000; we = 1'b1;
        tick();
        we = 1'b0;
        tick();
        chk("ovf_cleared", r_data, 16'h0005);
        while (cyc < 9 * 10 * CD + 8) begin
            chk($sformatf("chain_txd_%0d", cyc), {15'b0, txd}, {15'b0, exp_chain(cyc)});
            tick();
        end
        rd(8'h81, 16'h0002, "chain_done_status");

        // Reset in the middle of a frame
        wr(8'h80, 16'h005A);
        wr(8'h80, 16'h003C);
        wait_start();
        repeat (6) tick();
        reset = 1'b1;
        r_addr = 8'h84;
        tick();
        chk("midrst_txd", {15'b0, txd}, 16'h0001);
        chk("midrst_rdata", r_data, 16'h0000);
        reset = 1'b0;
`ifdef MINI16SC_DBUS_RESP_CYCLE_EN
        rd(8'h84, 16'h0000, "cycle_0");
        rd(8'h84, 16'h0001, "cycle_1");
        rd(8'h84, 16'h0002, "cycle_2");
        wr(8'h84, 16'h5555);
        rd(8'h84, 16'h0000, "cycle_clr");
        rd(8'h84, 16'h0001, "cycle_clr_1");
`else
        rd(8'h84, 16'h0000, "cycle_absent_0");
        rd(8'h84, 16'h0000, "cycle_absent_1");
        wr(8'h84, 16'h5555);
        rd(8'h84, 16'h0000, "cycle_absent_wr");
`endif
        rd(8'h81, 16'h0002, "midrst_status");
        rd(8'h82, 16'h0000, "midrst_gpio");
        for (int i = 0; i < 60; i++) begin
            chk($sformatf("midrst_idle_%0d", i), {15'b0, txd}, 16'h0001);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
